// File: rtl/hamming_pkg.sv
// Shared widths, controller states and result payload for the Hamming(7,4) link controller.
package hamming_pkg;

   localparam int unsigned DATA_W = 4;
   localparam int unsigned CODE_W = 7;
   localparam int unsigned SYN_W  = 3;
   localparam int unsigned POS_W  = 3;

   typedef enum logic [1:0] {IDLE, ENC, DEC, OUT} ctrl_state_t;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [SYN_W-1:0]  syndrome;
      logic              mismatch;
   } result_t;

   // Position 1..7 selects codeword bit 0..6; position 0 injects nothing.
   function automatic logic [CODE_W-1:0] pos_mask(input logic [POS_W-1:0] p);
      logic [CODE_W-1:0] m;
      m = '0;
      if (p != '0) m = CODE_W'(1) << (p - POS_W'(1));
      return m;
   endfunction

endpackage

// File: rtl/btn_toggle_sync.sv
// Push-button synchronizer with rising-edge detect; each press flips toggle_o once.
module btn_toggle_sync #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_i,
   output logic toggle_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;
   logic                   toggle_q;
   logic                   toggle_d;
   logic                   rise_c;

   assign rise_c = sync_q[SYNC_STAGES-1] & ~prev_q;

   always_comb begin
      toggle_d = toggle_q;
      if (rise_c) toggle_d = ~toggle_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q   <= '0;
         prev_q   <= 1'b0;
         toggle_q <= 1'b0;
      end else begin
         sync_q   <= {sync_q[SYNC_STAGES-2:0], btn_i};
         prev_q   <= sync_q[SYNC_STAGES-1];
         toggle_q <= toggle_d;
      end
   end

   assign toggle_o = toggle_q;

endmodule

// File: rtl/hamming_link_ctrl.sv
// Sequences one word through external Hamming(7,4) encoder/decoder with error injection.
// Define HAMMING_AUTO_INJECT_EN to take the injection position from an internal LFSR.
module hamming_link_ctrl
   import hamming_pkg::*;
#(
   parameter int unsigned CNT_W       = 8,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [POS_W-1:0]  err_pos,
   output logic [DATA_W-1:0] enc_data,
   input  logic [CODE_W-1:0] enc_code,
   output logic [CODE_W-1:0] dec_code,
   input  logic [SYN_W-1:0]  dec_syndrome,
   input  logic [DATA_W-1:0] dec_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [SYN_W-1:0]  out_syndrome,
   output logic              mismatch,
   output logic [CNT_W-1:0]  err_count,
   input  logic              btn,
   output logic              disp_sel
);

   ctrl_state_t       state_q, state_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [POS_W-1:0]  pos_q, pos_d;
   logic [CODE_W-1:0] code_q, code_d;
   result_t           res_q, res_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              in_ready_q, in_ready_d;
   logic              out_valid_q, out_valid_d;
`ifdef HAMMING_AUTO_INJECT_EN
   logic [POS_W-1:0]  lfsr_q, lfsr_d;
`endif

   always_comb begin
      state_d     = state_q;
      data_d      = data_q;
      pos_d       = pos_q;
      code_d      = code_q;
      res_d       = res_q;
      cnt_d       = cnt_q;
`ifdef HAMMING_AUTO_INJECT_EN
      lfsr_d      = lfsr_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               data_d  = in_data;
`ifdef HAMMING_AUTO_INJECT_EN
               pos_d   = lfsr_q;
               lfsr_d  = {lfsr_q[1:0], lfsr_q[2] ^ lfsr_q[1]};
`else
               pos_d   = err_pos;
`endif
               state_d = ENC;
            end
         end
         ENC: begin
            code_d  = enc_code ^ pos_mask(pos_q);
            state_d = DEC;
         end
         DEC: begin
            res_d.data     = dec_data;
            res_d.syndrome = dec_syndrome;
            res_d.mismatch = (dec_data != data_q);
            // Saturating count of words the decoder flagged.
            if ((dec_syndrome != '0) && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
            state_d = OUT;
         end
         OUT: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      in_ready_d  = (state_d == IDLE);
      out_valid_d = (state_d == OUT);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         data_q      <= '0;
         pos_q       <= '0;
         code_q      <= '0;
         res_q       <= '0;
         cnt_q       <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
`ifdef HAMMING_AUTO_INJECT_EN
         lfsr_q      <= 3'b001;
`endif
      end else begin
         state_q     <= state_d;
         data_q      <= data_d;
         pos_q       <= pos_d;
         code_q      <= code_d;
         res_q       <= res_d;
         cnt_q       <= cnt_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
`ifdef HAMMING_AUTO_INJECT_EN
         lfsr_q      <= lfsr_d;
`endif
      end
   end

   assign in_ready     = in_ready_q;
   assign out_valid    = out_valid_q;
   assign enc_data     = data_q;
   assign dec_code     = code_q;
   assign out_data     = res_q.data;
   assign out_syndrome = res_q.syndrome;
   assign mismatch     = res_q.mismatch;
   assign err_count    = cnt_q;

   btn_toggle_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_btn (
      .clk      (clk),
      .rst_n    (rst_n),
      .btn_i    (btn),
      .toggle_o (disp_sel)
   );

endmodule
